// File: rtl/scan_pkg.sv
// Shared types and helpers for the SDRAM min/max scan master.
// Optional running sum is enabled with SCAN_SUM_EN (see sdram_scan_master).
package scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  localparam int unsigned ByteW = 8;

  function automatic int unsigned byte_stride(input int unsigned data_w);
    return data_w / ByteW;
  endfunction

  // Most positive value of a w-bit element, zero-extended to 64 bits.
  function automatic logic [63:0] elem_max(input logic signed_mode, input int unsigned w);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    if (signed_mode) v[w-1] = 1'b0;
    return v;
  endfunction

  // Most negative value of a w-bit element, zero-extended to 64 bits.
  function automatic logic [63:0] elem_min(input logic signed_mode, input int unsigned w);
    logic [63:0] v;
    v = '0;
    if (signed_mode) v[w-1] = 1'b1;
    return v;
  endfunction

  // a < b on w-bit zero-extended elements; signed compare flips the sign bit.
  function automatic logic elem_lt(input logic [63:0] a, input logic [63:0] b,
                                   input logic signed_mode, input int unsigned w);
    logic [63:0] flip;
    flip = 64'(signed_mode) << (w - 1);
    return (a ^ flip) < (b ^ flip);
  endfunction

endpackage

// File: rtl/sdram_scan_master_if.sv
// Avalon-MM read-master bus bundle used by sdram_scan_master.
interface sdram_scan_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/scan_lane_reduce.sv
// One-cycle registered reduction of a packed bus word to its lane min/max
// (and lane sum when SCAN_SUM_EN is defined).
module scan_lane_reduce
  import scan_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ELEM_W = 16
`ifdef SCAN_SUM_EN
  ,
  parameter int unsigned SUM_W  = 34
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              signed_mode_i,
  output logic              valid_o,
  output logic [ELEM_W-1:0] lane_min_o,
  output logic [ELEM_W-1:0] lane_max_o
`ifdef SCAN_SUM_EN
  ,
  output logic [SUM_W-1:0]  lane_sum_o
`endif
);

  localparam int unsigned LANES = DATA_W / ELEM_W;

  logic              valid_q;
  logic [ELEM_W-1:0] min_d, min_q, max_d, max_q;
`ifdef SCAN_SUM_EN
  logic [SUM_W-1:0]  sum_d, sum_q;
`endif

  always_comb begin
    logic [ELEM_W-1:0] e;
    min_d = data_i[ELEM_W-1:0];
    max_d = data_i[ELEM_W-1:0];
    for (int unsigned l = 1; l < LANES; l++) begin
      e = data_i[l*ELEM_W +: ELEM_W];
      if (elem_lt(64'(e), 64'(min_d), signed_mode_i, ELEM_W)) min_d = e;
      if (elem_lt(64'(max_d), 64'(e), signed_mode_i, ELEM_W)) max_d = e;
    end
  end

`ifdef SCAN_SUM_EN
  always_comb begin
    logic [ELEM_W-1:0] e;
    sum_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      e = data_i[l*ELEM_W +: ELEM_W];
      if (signed_mode_i) sum_d = sum_d + SUM_W'($signed(e));
      else               sum_d = sum_d + SUM_W'(e);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
`ifdef SCAN_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        min_q <= min_d;
        max_q <= max_d;
`ifdef SCAN_SUM_EN
        sum_q <= sum_d;
`endif
      end
    end
  end

  assign valid_o    = valid_q;
  assign lane_min_o = min_q;
  assign lane_max_o = max_q;
`ifdef SCAN_SUM_EN
  assign lane_sum_o = sum_q;
`endif

endmodule

// File: rtl/sdram_scan_master.sv
// Avalon-MM read master scanning an SDRAM region to a running min/max.
// Define SCAN_SUM_EN to add the sum_out accumulator port.
module sdram_scan_master
  import scan_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ELEM_W   = 16,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready_in,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              signed_mode,
  output logic              done_out,
  output logic              busy_out,
  output logic [ELEM_W-1:0] max_out,
  output logic [ELEM_W-1:0] min_out,
`ifdef SCAN_SUM_EN
  output logic [ELEM_W+CNT_W+$clog2(DATA_W/ELEM_W)-1:0] sum_out,
`endif
  sdram_scan_master_if.master avm
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(byte_stride(DATA_W));
`ifdef SCAN_SUM_EN
  localparam int unsigned SUM_W = ELEM_W + CNT_W + $clog2(DATA_W / ELEM_W);
`endif

  state_t            state_d, state_q;
  logic              ready_q, ready_prev_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, issued_d, issued_q, recv_d, recv_q;
  logic [PEND_W-1:0] pend_d, pend_q;
  logic              sm_d, sm_q, read_d, read_q;
  logic [ELEM_W-1:0] min_d, min_q, max_d, max_q;
  logic              start, active, accept, rvalid;
  logic              lane_valid;
  logic [ELEM_W-1:0] lane_min, lane_max;
`ifdef SCAN_SUM_EN
  logic [SUM_W-1:0]  lane_sum, sum_d, sum_q;
`endif

  assign active = (state_q == StIssue) || (state_q == StDrain);
  assign start  = ready_q && !ready_prev_q && ((state_q == StIdle) || (state_q == StDone));
  assign accept = read_q && !avm.waitrequest;
  // Responses outside a scan are stray and must not touch the results.
  assign rvalid = avm.readdatavalid && active;

  scan_lane_reduce #(
    .DATA_W (DATA_W),
    .ELEM_W (ELEM_W)
`ifdef SCAN_SUM_EN
    ,
    .SUM_W  (SUM_W)
`endif
  ) u_reduce (
    .clk           (clk),
    .reset_n       (reset_n),
    .valid_i       (rvalid),
    .data_i        (avm.readdata),
    .signed_mode_i (sm_q),
    .valid_o       (lane_valid),
    .lane_min_o    (lane_min),
    .lane_max_o    (lane_max)
`ifdef SCAN_SUM_EN
    ,
    .lane_sum_o    (lane_sum)
`endif
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    sm_d     = sm_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    pend_d   = pend_q;
    min_d    = min_q;
    max_d    = max_q;
`ifdef SCAN_SUM_EN
    sum_d    = sum_q;
`endif

    if (accept) begin
      issued_d = issued_q + 1'b1;
      addr_d   = addr_q + Stride;
    end
    if (rvalid) recv_d = recv_q + 1'b1;
    if (accept && !rvalid)      pend_d = pend_q + 1'b1;
    else if (!accept && rvalid) pend_d = pend_q - 1'b1;

    if (lane_valid) begin
      if (elem_lt(64'(lane_min), 64'(min_q), sm_q, ELEM_W)) min_d = lane_min;
      if (elem_lt(64'(max_q), 64'(lane_max), sm_q, ELEM_W)) max_d = lane_max;
`ifdef SCAN_SUM_EN
      sum_d = sum_q + lane_sum;
`endif
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StIssue;
          addr_d   = start_addr;
          cnt_d    = word_count;
          sm_d     = signed_mode;
          issued_d = '0;
          recv_d   = '0;
          pend_d   = '0;
          min_d    = ELEM_W'(elem_max(signed_mode, ELEM_W));
          max_d    = ELEM_W'(elem_min(signed_mode, ELEM_W));
`ifdef SCAN_SUM_EN
          sum_d    = '0;
`endif
        end
      end
      StIssue: begin
        if (cnt_q == '0)            state_d = StDone;
        else if (issued_d == cnt_q) state_d = StDrain;
      end
      StDrain: begin
        if ((recv_q == cnt_q) && !lane_valid) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Registered request: holds through waitrequest since issued/pending cannot rise then.
    read_d = (state_q == StIssue) && (issued_d < cnt_q) && (pend_d < PEND_W'(MAX_PEND));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      ready_prev_q <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      sm_q         <= 1'b0;
      issued_q     <= '0;
      recv_q       <= '0;
      pend_q       <= '0;
      read_q       <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
`ifdef SCAN_SUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_in;
      ready_prev_q <= ready_q;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      sm_q         <= sm_d;
      issued_q     <= issued_d;
      recv_q       <= recv_d;
      pend_q       <= pend_d;
      read_q       <= read_d;
      min_q        <= min_d;
      max_q        <= max_d;
`ifdef SCAN_SUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign done_out    = (state_q == StDone);
  assign busy_out    = active;
  assign min_out     = min_q;
  assign max_out     = max_q;
  assign avm.address = addr_q;
  assign avm.read    = read_q;
`ifdef SCAN_SUM_EN
  assign sum_out     = sum_q;
`endif

endmodule

// File: tb/tb_sdram_scan_master.sv
// Directed + randomized bench for sdram_scan_master with an Avalon slave model.
module tb_sdram_scan_master;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ELEM_W   = 16;
  localparam int unsigned MAX_PEND = 2;
  localparam int unsigned CNT_W    = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic        signed_mode = 1'b0;
  logic        done_out, busy_out;
  logic [15:0] max_out, min_out;

  sdram_scan_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_if ();

  sdram_scan_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ELEM_W   (ELEM_W),
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ready_in    (ready_in),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .signed_mode (signed_mode),
    .done_out    (done_out),
    .busy_out    (busy_out),
    .max_out     (max_out),
    .min_out     (min_out),
    .avm         (avm_if)
  );

  always #5 clk = ~clk;

  // Slave configuration (written by the main sequence only).
  logic [31:0] mem [0:255];
  int          lat = 1;
  int          wait_pct = 0;
  int          spur_req = 0;
  logic [31:0] spur_data = '0;

  // Slave observations (written by the slave process only).
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t        rq[$];
  int          cyc = 0, nreads = 0, outstanding = 0, pend_viol = 0, hold_viol = 0;
  int          spur_done = 0;
  logic [31:0] addr_log [0:1023];

  initial begin
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          ws;
    rsp_t        r;
    prev_stall = 1'b0;
    prev_addr  = '0;
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    avm_if.readdata      = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rq.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
        avm_if.waitrequest   = 1'b0;
        avm_if.readdatavalid = 1'b0;
      end else begin
        cyc++;
        if (prev_stall && !(avm_if.read === 1'b1 && avm_if.address === prev_addr)) hold_viol++;
        avm_if.readdatavalid = 1'b0;
        avm_if.readdata      = $urandom;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          avm_if.readdatavalid = 1'b1;
          avm_if.readdata      = rq[0].data;
          void'(rq.pop_front());
          outstanding--;
        end else if (spur_req != spur_done) begin
          avm_if.readdatavalid = 1'b1;
          avm_if.readdata      = spur_data;
          spur_done++;
        end
        ws = ($urandom_range(99) < wait_pct);
        avm_if.waitrequest = ws;
        if (avm_if.read === 1'b1 && !ws) begin
          addr_log[nreads % 1024] = avm_if.address;
          r.due  = cyc + lat;
          r.data = mem[avm_if.address[9:2]];
          rq.push_back(r);
          nreads++;
          outstanding++;
          if (outstanding > int'(MAX_PEND)) pend_viol++;
        end
        prev_stall = (avm_if.read === 1'b1) && ws;
        prev_addr  = avm_if.address;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: fold every 16-bit element in address order using plain integers.
  function automatic void model(input logic [31:0] addr, input int cnt, input bit sm,
                                output logic [15:0] mn, output logic [15:0] mx);
    int          lo, hi, v;
    logic [31:0] w;
    logic [15:0] e;
    logic [7:0]  idx;
    lo = sm ? 32767 : 65535;
    hi = sm ? -32768 : 0;
    idx = addr[9:2];
    for (int k = 0; k < cnt; k++) begin
      w = mem[idx];
      for (int l = 0; l < 2; l++) begin
        e = w[16*l +: 16];
        v = sm ? int'($signed(e)) : int'(e);
        if (v < lo) lo = v;
        if (v > hi) hi = v;
      end
      idx = idx + 8'd1;
    end
    mn = lo[15:0];
    mx = hi[15:0];
  endfunction

  task automatic start_scan(input logic [31:0] addr, input int cnt, input bit sm);
    ready_in = 1'b0;
    step(2);
    start_addr  = addr;
    word_count  = cnt[15:0];
    signed_mode = sm;
    ready_in    = 1'b1;
    step(2);
    start_addr  = 32'hFFFF_FFFC;
    word_count  = 16'hFFFF;
    signed_mode = ~sm;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_out !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, done_out}, 32'd1);
  endtask

  task automatic verify_scan(input string tag, input int base, input logic [31:0] addr,
                             input int cnt, input bit sm);
    logic [15:0] emn, emx;
    int          bad;
    model(addr, cnt, sm, emn, emx);
    check({tag, "_min"}, {16'd0, min_out}, {16'd0, emn});
    check({tag, "_max"}, {16'd0, max_out}, {16'd0, emx});
    check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_nreads"}, nreads - base, cnt);
    bad = 0;
    for (int k = 0; k < cnt; k++)
      if (addr_log[(base + k) % 1024] !== addr + 32'(4 * k)) bad++;
    check({tag, "_addr_seq"}, bad, 0);
  endtask

  task automatic run_scan(input string tag, input logic [31:0] addr, input int cnt,
                          input bit sm);
    int base;
    base = nreads;
    start_scan(addr, cnt, sm);
    wait_done({tag, "_done"}, 5000);
    step(2);
    verify_scan(tag, base, addr, cnt, sm);
  endtask

  initial begin
    logic [31:0] a;
    int          base;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0003_0010;
    mem[1] = 32'hFFFF_0001;
    mem[2] = 32'h0200_0020;
    mem[3] = 32'h0005_7FFF;

    reset_n = 1'b0;
    step(3);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_min", {16'd0, min_out}, 32'd0);
    check("rst_max", {16'd0, max_out}, 32'd0);
    check("rst_read", {31'd0, avm_if.read}, 32'd0);
    check("rst_addr", avm_if.address, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Zero-wait unsigned scan with known data.
    lat = 1;
    wait_pct = 0;
    run_scan("unsigned4", 32'h0, 4, 1'b0);
    check("unsigned4_max_lit", {16'd0, max_out}, 32'h0000_FFFF);
    check("unsigned4_min_lit", {16'd0, min_out}, 32'h0000_0001);

    // Stray response while DONE must be ignored.
    spur_data = 32'h0000_0000;
    spur_req++;
    step(4);
    check("spurious_min", {16'd0, min_out}, 32'h0000_0001);
    check("spurious_done", {31'd0, done_out}, 32'd1);

    run_scan("signed4", 32'h0, 4, 1'b1);
    check("signed4_max_lit", {16'd0, max_out}, 32'h0000_7FFF);
    check("signed4_min_lit", {16'd0, min_out}, 32'h0000_FFFF);

    run_scan("zero_len", 32'h40, 0, 1'b0);
    check("zero_len_min_lit", {16'd0, min_out}, 32'h0000_FFFF);
    check("zero_len_max_lit", {16'd0, max_out}, 32'h0000_0000);

    // Backpressure with long response latency.
    lat = 6;
    wait_pct = 50;
    a = {22'd0, 8'($urandom_range(255)), 2'b00};
    run_scan("bp_unsigned", a, 100, 1'b0);
    a = {22'd0, 8'($urandom_range(255)), 2'b00};
    run_scan("bp_signed", a, 100, 1'b1);
    check("bp_pend_limit", pend_viol, 0);
    check("bp_addr_hold", hold_viol, 0);

    // ready_in held high after done: no restart.
    base = nreads;
    step(10);
    check("hold_high_done", {31'd0, done_out}, 32'd1);
    check("hold_high_noreads", nreads - base, 0);

    // Start timing and mid-scan ready_in toggles.
    wait_pct = 30;
    a = {22'd0, 8'($urandom_range(255)), 2'b00};
    ready_in = 1'b0;
    step(2);
    start_addr  = a;
    word_count  = 16'd30;
    signed_mode = 1'b1;
    base        = nreads;
    ready_in    = 1'b1;
    step(1);
    check("hs_done_at_n1", {31'd0, done_out}, 32'd1);
    step(1);
    check("hs_done_at_n2", {31'd0, done_out}, 32'd0);
    check("hs_busy_at_n2", {31'd0, busy_out}, 32'd1);
    step(1);
    check("hs_read_at_n3", {31'd0, avm_if.read}, 32'd1);
    step(3);
    ready_in = 1'b0;
    step(2);
    ready_in = 1'b1;
    step(2);
    ready_in = 1'b0;
    step(2);
    ready_in = 1'b1;
    wait_done("hs_done", 5000);
    step(2);
    verify_scan("hs", base, a, 30, 1'b1);

    // Reset while draining, then a normal scan.
    wait_pct = 0;
    a = {22'd0, 8'($urandom_range(255)), 2'b00};
    base = nreads;
    start_scan(a, 20, 1'b0);
    for (int n = 0; n < 1000 && (nreads - base) < 20; n++) step(1);
    check("rst_mid_issued", nreads - base, 20);
    check("rst_mid_busy", {31'd0, busy_out}, 32'd1);
    reset_n  = 1'b0;
    ready_in = 1'b0;
    #1;
    check("rst_mid_done", {31'd0, done_out}, 32'd0);
    check("rst_mid_busy0", {31'd0, busy_out}, 32'd0);
    check("rst_mid_min", {16'd0, min_out}, 32'd0);
    check("rst_mid_max", {16'd0, max_out}, 32'd0);
    check("rst_mid_read", {31'd0, avm_if.read}, 32'd0);
    check("rst_mid_addr", avm_if.address, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(3);
    check("post_rst_idle", {30'd0, busy_out, done_out}, 32'd0);
    a = {22'd0, 8'($urandom_range(255)), 2'b00};
    run_scan("post_rst", a, 25, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
